// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a wrapping range of register-file addresses and
// streams each captured value, plus an optional ALU-flags trailer, over valid/ready.
module reg_dump_reader #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          with_flags,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic [2:0]    alu_flags,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    FLAGS = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [AW-1:0] NREGS_W   = AW'(NREGS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE_W     = AW'(1);
  localparam logic [AW-1:0] ZERO_W    = {AW{1'b0}};

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? ZERO_W : p + ONE_W;
  endfunction

  state_t        state_r, state_s;
  logic [AW-1:0] ptr_r, ptr_s;
  logic [AW-1:0] remain_r, remain_s;
  logic          wf_r, wf_s;
  logic [DW-1:0] dout_r, dout_s;
  logic          valid_r, valid_s;
  logic          last_r, last_s;
  logic          busy_r, done_r;
  logic          handshake_s;
  logic [AW-1:0] clamp_s;
  logic [DW-1:0] flags_word_s;

  assign handshake_s  = valid_r & dout_ready;
  assign clamp_s      = (len > NREGS_W) ? NREGS_W : len;
  assign flags_word_s = {{(DW-3){1'b0}}, alu_flags};

  // Next-state and next-register-value logic for the dump sequencer.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    remain_s = remain_r;
    wf_s     = wf_r;
    dout_s   = dout_r;
    valid_s  = valid_r;
    last_s   = last_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          ptr_s    = base % NREGS_W;
          remain_s = clamp_s;
          wf_s     = with_flags;
          state_s  = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // An empty range still spends this cycle so start-to-done timing is uniform.
        if (remain_r != ZERO_W) begin
          dout_s   = rd_data;
          valid_s  = 1'b1;
          last_s   = (remain_r == ONE_W) && !wf_r;
          remain_s = remain_r - ONE_W;
          ptr_s    = wrap_inc(ptr_r);
          state_s  = SEND;
        end else if (wf_r) begin
          dout_s  = flags_word_s;
          valid_s = 1'b1;
          last_s  = 1'b1;
          state_s = FLAGS;
        end else begin
          state_s = FIN;
        end
      end
      SEND: begin
        if (handshake_s) begin
          if (remain_r != ZERO_W) begin
            dout_s   = rd_data;
            last_s   = (remain_r == ONE_W) && !wf_r;
            remain_s = remain_r - ONE_W;
            ptr_s    = wrap_inc(ptr_r);
            state_s  = SEND;
          end else if (wf_r) begin
            dout_s  = flags_word_s;
            last_s  = 1'b1;
            state_s = FLAGS;
          end else begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            state_s = FIN;
          end
        end else begin
          state_s = SEND;
        end
      end
      FLAGS: begin
        if (handshake_s) begin
          valid_s = 1'b0;
          last_s  = 1'b0;
          state_s = FIN;
        end else begin
          state_s = FLAGS;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any dump immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      ptr_r    <= ZERO_W;
      remain_r <= ZERO_W;
      wf_r     <= 1'b0;
      dout_r   <= {DW{1'b0}};
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      remain_r <= remain_s;
      wf_r     <= wf_s;
      dout_r   <= dout_s;
      valid_r  <= valid_s;
      last_r   <= last_s;
      busy_r   <= (state_s == LOAD) || (state_s == SEND) || (state_s == FLAGS);
      done_r   <= (state_s == FIN);
    end
  end

  assign rd_addr    = ptr_r;
  assign dout       = dout_r;
  assign dout_valid = valid_r;
  assign dout_last  = last_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a table of dump configurations with
// hand-computed beat sequences, plus backpressure, mid-dump write and reset cases.
module tb_reg_dump_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NREGS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          with_flags;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [2:0]    alu_flags;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NREGS];
  int n_checks = 0;
  int n_fail   = 0;

  assign rd_data = regs[rd_addr[2:0]];

  always #5 clk = ~clk;

  reg_dump_reader #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .with_flags(with_flags), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_flags(alu_flags), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0]         base;
    logic [AW-1:0]         len;
    logic                  wf;
    logic [2:0]            flags;
    int                    n;
    int                    exp_done;
    logic [8:0][DW-1:0]    exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge. cyc m is the cycle after edge N+m-1, N = accept edge.
  task automatic run_dump(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic wf,
                          input logic [2:0] fl, input int n, input logic [8:0][DW-1:0] exp,
                          input logic [31:0] rdy_pat, input int exp_done, input int restart_cyc,
                          input int wr_cyc, input int wr_idx, input logic [DW-1:0] wr_val);
    int beat;
    int done_cyc;
    logic stalled;
    logic [DW-1:0] held;
    base = b; len = l; with_flags = wf; alu_flags = fl; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = b ^ 4'h3; len = 4'h1; with_flags = ~wf;
    beat = 0; done_cyc = 0; stalled = 1'b0; held = 8'h00;
    for (int cyc = 1; cyc < 32 && done_cyc == 0; cyc++) begin
      start = (cyc == restart_cyc);
      dout_ready = rdy_pat[cyc];
      if (cyc == wr_cyc) regs[wr_idx] = wr_val;
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (stalled) begin
        check("hold_valid", 32'(dout_valid), 32'd1);
        check("hold_data", 32'(dout), 32'(held));
      end
      if (dout_valid && dout_ready) begin
        if (beat < n) begin
          check("beat_data", 32'(dout), 32'(exp[beat]));
          check("beat_last", 32'(dout_last), 32'(beat == n - 1));
        end else begin
          check("extra_beat", 32'(beat + 1), 32'(n));
        end
        beat++;
      end else if (!dout_valid) begin
        check("last_without_valid", 32'(dout_last), 32'd0);
      end
      stalled = dout_valid && !dout_ready;
      held = dout;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    start = 1'b0; dout_ready = 1'b1;
    check("beat_count", 32'(beat), 32'(n));
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(dout_valid), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base = 4'h0; len = 4'h0; with_flags = 1'b0;
    alu_flags = 3'b000; dout_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) regs[i] = 8'h10 + 8'(i);

    vecs[0] = '{base: 4'd0,  len: 4'd8,  wf: 1'b0, flags: 3'b000, n: 8, exp_done: 10,
                exp: {8'h00, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[1] = '{base: 4'd6,  len: 4'd4,  wf: 1'b1, flags: 3'b101, n: 5, exp_done: 7,
                exp: {32'h0, 8'h05, 8'h11, 8'h10, 8'h17, 8'h16}};
    vecs[2] = '{base: 4'd0,  len: 4'd0,  wf: 1'b0, flags: 3'b000, n: 0, exp_done: 2,
                exp: 72'h0};
    vecs[3] = '{base: 4'd3,  len: 4'd0,  wf: 1'b1, flags: 3'b011, n: 1, exp_done: 3,
                exp: {64'h0, 8'h03}};
    vecs[4] = '{base: 4'd13, len: 4'd10, wf: 1'b0, flags: 3'b000, n: 8, exp_done: 10,
                exp: {8'h00, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'h17, 8'h16, 8'h15}};
    vecs[5] = '{base: 4'd7,  len: 4'd2,  wf: 1'b1, flags: 3'b110, n: 3, exp_done: 5,
                exp: {48'h0, 8'h06, 8'h10, 8'h17}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_dump(vecs[i].base, vecs[i].len, vecs[i].wf, vecs[i].flags, vecs[i].n, vecs[i].exp,
               32'hFFFF_FFFF, vecs[i].exp_done, -1, -1, 0, 8'h00);

    // Backpressure: ready low for two cycles while the second beat is presented.
    run_dump(4'd2, 4'd3, 1'b0, 3'b000, 3, {48'h0, 8'h14, 8'h13, 8'h12},
             32'hFFFF_FFE7, 7, -1, -1, 0, 8'h00);

    // Start while busy is ignored; reg5 overwritten while reg4 is on the bus.
    run_dump(4'd4, 4'd4, 1'b0, 3'b000, 4, {40'h0, 8'h17, 8'h16, 8'hAA, 8'h14},
             32'hFFFF_FFFF, 6, 3, 2, 5, 8'hAA);
    regs[5] = 8'h15;

    // Start raised during the done cycle is ignored.
    run_dump(4'd1, 4'd0, 1'b0, 3'b000, 0, 72'h0, 32'hFFFF_FFFF, 2, 2, -1, 0, 8'h00);

    // Reset during the third beat aborts the dump.
    base = 4'd0; len = 4'd8; with_flags = 1'b0; dout_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_beat", 32'(dout), 32'h12);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", 32'(dout_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_last", 32'(dout_last), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
      check("idle_after_abort", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    run_dump(vecs[0].base, vecs[0].len, vecs[0].wf, vecs[0].flags, vecs[0].n, vecs[0].exp,
             32'hFFFF_FFFF, vecs[0].exp_done, -1, -1, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
